// File: rtl/priv_trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// PRIV_TRAP_VECTORED_EN selects vectored interrupt dispatch.
package priv_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2
  } trap_state_t;

  localparam logic [1:0] MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MODE_VECTORED = 2'd1;

  function automatic int int_flag_pos(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/priv_prio_enc.sv
// Fixed-priority encoder, lowest-first or highest-first.
// Shared by the exception and interrupt arbiters.
module priv_prio_enc #(
  parameter int W          = 8,
  parameter bit HIGH_FIRST = 1'b0,
  parameter int IW         = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Later loop iterations overwrite earlier ones, so scan
  // toward the winning end.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < W; i++)
        if (req_i[i]) idx_o = IW'(i);
    end else begin
      for (int i = W - 1; i >= 0; i--)
        if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Trap capture, arbitration and commit for machine mode.
// Define PRIV_TRAP_VECTORED_EN for vectored interrupt targets.
module priv_trap_ctrl
  import priv_trap_pkg::*;
#(
  parameter int NUM_INT = 12,
  parameter int NUM_EXC = 16,
  parameter int XLEN    = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_INT-1:0] int_src,
  input  logic [NUM_INT-1:0] int_clr,
  input  logic [NUM_INT-1:0] mie,
  input  logic               gie,
  input  logic [NUM_EXC-1:0] exc,
  input  logic [XLEN-1:0]    epc,
  input  logic [XLEN-1:0]    tval,
  input  logic               pipe_clear,
  input  logic               mret,
  input  logic [XLEN-1:0]    mepc,
  input  logic [XLEN-1:0]    mtvec,
  output logic [NUM_INT-1:0] mip,
  output logic               busy,
  output logic               trap_rup,
  output logic [XLEN-1:0]    cause_next,
  output logic [XLEN-1:0]    epc_next,
  output logic [XLEN-1:0]    tval_next,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc
);

  localparam int FLAG = int_flag_pos(XLEN);
  localparam int EIW  = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
  localparam int IIW  = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

  trap_state_t state_q, state_d;

  logic [NUM_INT-1:0] mip_q;
  logic [XLEN-1:0]    cause_q, cause_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [XLEN-1:0]    tval_q, tval_d;

  logic [NUM_INT-1:0] int_req;
  logic               exc_v, int_v;
  logic [EIW-1:0]     exc_idx;
  logic [IIW-1:0]     int_idx;
  logic               mret_take;
  logic               commit;
  logic [XLEN-1:0]    base, target;

  assign int_req = mip_q & mie;

  priv_prio_enc #(
    .W         (NUM_EXC),
    .HIGH_FIRST(1'b0)
  ) u_exc_enc (
    .req_i  (exc),
    .valid_o(exc_v),
    .idx_o  (exc_idx)
  );

  priv_prio_enc #(
    .W         (NUM_INT),
    .HIGH_FIRST(1'b1)
  ) u_int_enc (
    .req_i  (int_req),
    .valid_o(int_v),
    .idx_o  (int_idx)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    mret_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_v) begin
          cause_d       = XLEN'(exc_idx);
          cause_d[FLAG] = 1'b0;
          epc_d         = epc;
          tval_d        = tval;
          state_d       = ST_WAIT;
        end else if (gie && int_v) begin
          cause_d       = XLEN'(int_idx);
          cause_d[FLAG] = 1'b1;
          epc_d         = epc;
          tval_d        = '0;
          state_d       = ST_WAIT;
        end else begin
          mret_take = mret && !RST;
        end
      end
      ST_WAIT: begin
        if (pipe_clear) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      mip_q   <= '0;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      mip_q   <= (mip_q | int_src) & ~int_clr;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end

  assign base = {mtvec[XLEN-1:2], 2'b00};

`ifdef PRIV_TRAP_VECTORED_EN
  // The flag bit sits above the shifted window, so the
  // offset is the bare channel index times four.
  always_comb begin
    target = base;
    if (cause_q[FLAG] && mtvec[1:0] == MODE_VECTORED)
      target = base + {cause_q[XLEN-3:0], 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = ^mtvec[1:0];
  assign target      = base;
`endif

  // A reset landing on the commit cycle suppresses the strobes.
  assign commit     = (state_q == ST_COMMIT) && !RST;
  assign busy       = (state_q != ST_IDLE);
  assign trap_rup   = commit;
  assign insert_pc  = commit || mret_take;
  assign priv_pc    = commit    ? target :
                      mret_take ? mepc   : '0;
  assign mip        = mip_q;
  assign cause_next = cause_q;
  assign epc_next   = epc_q;
  assign tval_next  = tval_q;

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Scoreboarded bench for priv_trap_ctrl: directed scenarios then
// randomized traffic against a behavioural trap model.
module tb_priv_trap_ctrl;

  localparam int NI = 12;
  localparam int NE = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NI-1:0] int_src = '0;
  logic [NI-1:0] int_clr = '0;
  logic [NI-1:0] mie = '0;
  logic          gie = 1'b0;
  logic [NE-1:0] exc = '0;
  logic [31:0]   epc = '0;
  logic [31:0]   tval = '0;
  logic          pipe_clear = 1'b0;
  logic          mret = 1'b0;
  logic [31:0]   mepc = '0;
  logic [31:0]   mtvec = '0;
  logic [NI-1:0] mip;
  logic          busy, trap_rup, insert_pc;
  logic [31:0]   cause_next, epc_next, tval_next, priv_pc;

  priv_trap_ctrl #(.NUM_INT(NI), .NUM_EXC(NE), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .int_src(int_src), .int_clr(int_clr),
    .mie(mie), .gie(gie), .exc(exc), .epc(epc), .tval(tval),
    .pipe_clear(pipe_clear), .mret(mret), .mepc(mepc),
    .mtvec(mtvec), .mip(mip), .busy(busy), .trap_rup(trap_rup),
    .cause_next(cause_next), .epc_next(epc_next),
    .tval_next(tval_next), .insert_pc(insert_pc),
    .priv_pc(priv_pc)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          irq;
    int unsigned idx;
    bit [31:0]   epc;
    bit [31:0]   tval;
  } trap_t;

  typedef struct {
    bit          busy;
    bit [NI-1:0] mip;
    bit [31:0]   cause, epc, tval;
    bit          ev;
  } st_t;

  typedef struct {
    bit        rup;
    bit [31:0] pc;
  } ev_t;

  st_t stq[$];
  ev_t evq[$];

  // Model: pending set, a phase (0 free, 1 holding, 2 committing)
  // and the trap currently owned.
  bit [NI-1:0] pend = '0;
  int          phase = 0;
  trap_t       cur = '{default: 0};

  function automatic bit [31:0] cause_of(trap_t t);
    return (t.irq ? 32'h8000_0000 : 32'h0) + t.idx;
  endfunction

  function automatic bit [31:0] target_of(trap_t t, bit [31:0] tv);
    bit [31:0] b;
    b = tv & ~32'h3;
`ifdef PRIV_TRAP_VECTORED_EN
    if (t.irq && (tv & 32'h3) == 32'h1) return b + 4 * t.idx;
`endif
    return b;
  endfunction

  task automatic model_cycle();
    st_t   s;
    ev_t   e;
    trap_t nt;
    bit    found;
    found = 0;
    nt = '{default: 0};
    e = '{default: 0};
    s.busy = (phase != 0);
    s.mip = pend;
    s.cause = cause_of(cur);
    s.epc = cur.epc;
    s.tval = cur.tval;
    s.ev = 0;
    if (!RST) begin
      if (phase == 2) begin
        e.rup = 1;
        e.pc = target_of(cur, mtvec);
        s.ev = 1;
      end else if (phase == 0) begin
        for (int i = NE - 1; i >= 0; i--)
          if (exc[i]) begin found = 1; nt.idx = i; end
        if (found) begin
          nt.irq = 0; nt.epc = epc; nt.tval = tval;
        end else if (gie) begin
          for (int i = 0; i < NI; i++)
            if (pend[i] && mie[i]) begin found = 1; nt.idx = i; end
          nt.irq = 1; nt.epc = epc; nt.tval = 0;
        end
        if (!found && mret) begin
          e.rup = 0; e.pc = mepc; s.ev = 1;
        end
      end
    end
    stq.push_back(s);
    if (s.ev) evq.push_back(e);
    if (RST) begin
      pend = '0; phase = 0; cur = '{default: 0};
    end else begin
      pend = (pend | int_src) & ~int_clr;
      if (phase == 2) phase = 0;
      else if (phase == 1) begin
        if (pipe_clear) phase = 2;
      end else if (found) begin
        cur = nt; phase = 1;
      end
    end
  endtask

  always @(negedge CLK) begin
    st_t s;
    ev_t e;
    #2;
    if (stq.size() > 0) begin
      s = stq.pop_front();
      chk("busy", busy, s.busy);
      chk("mip", mip, s.mip);
      chk("cause_next", cause_next, s.cause);
      chk("epc_next", epc_next, s.epc);
      chk("tval_next", tval_next, s.tval);
      if (s.ev || trap_rup || insert_pc) begin
        if (evq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_strobe: rup=%0b ins=%0b want none",
                   trap_rup, insert_pc);
        end else begin
          e = evq.pop_front();
          chk("ev_insert_pc", insert_pc, 1);
          chk("ev_trap_rup", trap_rup, e.rup);
          chk("ev_priv_pc", priv_pc, e.pc);
        end
      end else begin
        chk("idle_priv_pc", priv_pc, 0);
      end
    end
  end

  task automatic eval();
    model_cycle();
    #3;
  endtask

  task automatic adv();
    @(negedge CLK);
  endtask

  task automatic cyc();
    eval();
    adv();
  endtask

  initial begin
    adv();
    eval();
    chk("rst_busy", busy, 0);
    chk("rst_rup", trap_rup, 0);
    chk("rst_ins", insert_pc, 0);
    adv();
    RST = 0;
    cyc();

    // Reset while holding a captured exception.
    exc = 16'h0004;
    cyc();
    exc = 0;
    eval(); chk("wait_busy", busy, 1); adv();
    RST = 1;
    eval(); chk("rst_wait_rup", trap_rup, 0); adv();
    RST = 0;
    eval();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cause", cause_next, 0);
    chk("post_rst_pc", priv_pc, 0);
    adv();

    // Lowest exception wins.
    mtvec = 32'h1000; exc = 16'h0006; epc = 32'h100;
    tval = 32'hBAD; pipe_clear = 1;
    cyc();
    exc = 0;
    cyc();
    eval();
    chk("exc_rup", trap_rup, 1);
    chk("exc_cause", cause_next, 1);
    chk("exc_epc", epc_next, 32'h100);
    chk("exc_tval", tval_next, 32'hBAD);
    chk("exc_pc", priv_pc, 32'h1000);
    adv();

    // Highest enabled interrupt wins.
    mie = 12'hFFF; gie = 1; int_src = 12'h888;
    cyc();
    int_src = 0;
    eval(); chk("irq_mip", mip, 12'h888); adv();
    gie = 0;
    cyc();
    eval();
    chk("irq_cause", cause_next, 32'h8000_000B);
    chk("irq_tval", tval_next, 0);
    chk("irq_mip_hold", mip, 12'h888);
    adv();
    cyc();
    int_clr = 12'h800;
    cyc();
    int_clr = 0;
    eval(); chk("irq_mip_clr", mip, 12'h088); adv();

    // Gating by gie and mie.
    int_clr = 12'hFFF; cyc();
    int_clr = 0; int_src = 12'h080; cyc();
    int_src = 0; gie = 0; mie = 12'hFFF; pipe_clear = 0;
    cyc();
    eval(); chk("gate_gie", busy, 0); adv();
    gie = 1; mie = 12'hF7F;
    cyc();
    eval(); chk("gate_mie", busy, 0); adv();
    mtvec = 32'h1001; mie = 12'h080;
    cyc();
    gie = 0; pipe_clear = 1;
    cyc();
    eval();
    chk("gate_rup", trap_rup, 1);
    chk("gate_cause", cause_next, 32'h8000_0007);
`ifdef PRIV_TRAP_VECTORED_EN
    chk("vec_pc", priv_pc, 32'h101C);
`else
    chk("vec_pc", priv_pc, 32'h1000);
`endif
    adv();
    int_clr = 12'h080; cyc();
    int_clr = 0;

    // Commit held off by pipe_clear.
    mtvec = 32'h1000; pipe_clear = 0; exc = 16'h0001;
    epc = 32'h300; tval = 32'h44;
    cyc();
    for (int i = 0; i < 10; i++) begin
      exc = 16'($urandom);
      eval();
      chk("hold_busy", busy, 1);
      chk("hold_rup", trap_rup, 0);
      chk("hold_cause", cause_next, 0);
      adv();
    end
    exc = 0; pipe_clear = 1;
    cyc();
    eval();
    chk("hold_commit", trap_rup, 1);
    chk("hold_epc", epc_next, 32'h300);
    adv();

    // mret redirect and mret losing to a trap.
    mret = 1; mepc = 32'h2000;
    eval();
    chk("mret_ins", insert_pc, 1);
    chk("mret_pc", priv_pc, 32'h2000);
    chk("mret_rup", trap_rup, 0);
    adv();
    exc = 16'h0008; epc = 32'h500;
    eval(); chk("mret_drop", insert_pc, 0); adv();
    mret = 0; exc = 0;
    cyc();
    eval();
    chk("mret_trap_cause", cause_next, 3);
    chk("mret_trap_pc", priv_pc, 32'h1000);
    adv();

    for (int n = 0; n < 4000; n++) begin
      RST = ($urandom_range(0, 99) == 0);
      exc = ($urandom_range(0, 7) == 0) ? 16'($urandom) : '0;
      int_src = ($urandom_range(0, 3) == 0) ?
                12'(1 << $urandom_range(0, 11)) : '0;
      int_clr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : '0;
      mie = 12'($urandom);
      gie = ($urandom_range(0, 3) != 0);
      pipe_clear = 1'($urandom_range(0, 1));
      mret = ($urandom_range(0, 7) == 0);
      mtvec = $urandom;
      epc = $urandom;
      tval = $urandom;
      mepc = $urandom;
      cyc();
    end

    RST = 0; exc = 0; gie = 0; mret = 0; pipe_clear = 1;
    int_src = 0; int_clr = 0;
    for (int i = 0; i < 4; i++) cyc();
    #3;
    chk("evq_drained", evq.size(), 0);
    chk("stq_drained", stq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
